max_part_err_monitor: RTL and testbench

Streaming error-statistics stage that sits directly downstream of the partitioned approximate max circuit. Each sample pairs that circuit's 5-bit approximate output word with the exact max circuit's output for the same input pattern. The block accumulates error metrics over fixed windows of WIN_LEN samples and hands out one result record per window over a valid/ready handshake. It is the on-chip QoR check for approximated partitions.

---
 rtl/max_part_err_pkg.sv | 25 ++
 rtl/max_part_err_if.sv | 34 +++
 rtl/max_part_err_diff.sv | 70 +++++++
 rtl/max_part_err_monitor.sv | 183 ++++++++++++++++++
 tb/tb_max_part_err_monitor.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/max_part_err_pkg.sv
// Shared types, defaults and helpers for the max-partition error monitor.
// Holds the FSM state encoding and a saturating adder.
package max_part_err_pkg;

    localparam int DEF_OUT_W   = 5;
    localparam int DEF_CNT_W   = 32;
    localparam int DEF_WIN_LEN = 1024;

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Sum clamps at lim; callers keep a <= lim.
    function automatic logic [63:0] sat_add(
        input logic [63:0] a,
        input logic [63:0] b,
        input logic [63:0] lim
    );
        logic [64:0] s;
        s = {1'b0, a} + {1'b0, b};
        return (s > {1'b0, lim}) ? lim : s[63:0];
    endfunction

endpackage

// File: rtl/max_part_err_if.sv
// Sample-in / result-out bundle for the error monitor.
// slave is the monitor side, master the producer/consumer side.
interface max_part_err_if
    import max_part_err_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int CNT_W = DEF_CNT_W
);

    logic                   in_valid;
    logic                   in_ready;
    logic [OUT_W-1:0]       approx_w;
    logic [OUT_W-1:0]       exact_w;
    logic                   res_valid;
    logic                   res_ready;
    logic [CNT_W-1:0]       res_mism;
    logic [CNT_W-1:0]       res_ham;
    logic [CNT_W-1:0]       res_sae;
    logic [OUT_W-1:0]       res_maxe;
    logic [OUT_W*CNT_W-1:0] res_bitcnt;

    modport master (
        output in_valid, approx_w, exact_w, res_ready,
        input  in_ready, res_valid, res_mism, res_ham,
        input  res_sae, res_maxe, res_bitcnt
    );

    modport slave (
        input  in_valid, approx_w, exact_w, res_ready,
        output in_ready, res_valid, res_mism, res_ham,
        output res_sae, res_maxe, res_bitcnt
    );

endinterface

// File: rtl/max_part_err_diff.sv
// Stage 1: registers per-sample mismatch, Hamming distance,
// absolute error and flip vector, plus valid and window-last tags.
module max_part_err_diff
    import max_part_err_pkg::*;
#(
    parameter int OUT_W = DEF_OUT_W,
    parameter int HW    = $clog2(DEF_OUT_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             vld_i,
    input  logic             last_i,
    input  logic [OUT_W-1:0] a_i,
    input  logic [OUT_W-1:0] e_i,
    output logic             vld_o,
    output logic             last_o,
    output logic             mism_o,
    output logic [HW-1:0]    ham_o,
    output logic [OUT_W-1:0] ae_o,
    output logic [OUT_W-1:0] flip_o
);

    logic             vld_q, last_q, mism_q;
    logic             mism_d;
    logic [HW-1:0]    ham_q, ham_d;
    logic [OUT_W-1:0] ae_q, ae_d;
    logic [OUT_W-1:0] flip_q, flip_d;
    logic [OUT_W:0]   wide;

    always_comb begin
        flip_d = a_i ^ e_i;
        mism_d = |flip_d;
        ham_d  = '0;
        for (int i = 0; i < OUT_W; i++) begin
            ham_d = ham_d + HW'(flip_d[i]);
        end
        if (a_i >= e_i) begin
            wide = {1'b0, a_i} - {1'b0, e_i};
        end else begin
            wide = {1'b0, e_i} - {1'b0, a_i};
        end
        ae_d = wide[OUT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q  <= 1'b0;
            last_q <= 1'b0;
            mism_q <= 1'b0;
            ham_q  <= '0;
            ae_q   <= '0;
            flip_q <= '0;
        end else begin
            vld_q  <= vld_i;
            last_q <= last_i;
            mism_q <= mism_d;
            ham_q  <= ham_d;
            ae_q   <= ae_d;
            flip_q <= flip_d;
        end
    end

    assign vld_o  = vld_q;
    assign last_o = last_q;
    assign mism_o = mism_q;
    assign ham_o  = ham_q;
    assign ae_o   = ae_q;
    assign flip_o = flip_q;

endmodule

// File: rtl/max_part_err_monitor.sv
// Windowed QoR error statistics for the partitioned approximate max.
// ERR_BITCNT_EN builds the per-bit flip counters behind res_bitcnt.
module max_part_err_monitor
    import max_part_err_pkg::*;
#(
    parameter int OUT_W   = DEF_OUT_W,
    parameter int CNT_W   = DEF_CNT_W,
    parameter int WIN_LEN = DEF_WIN_LEN
) (
    input logic            clk,
    input logic            rst_n,
    max_part_err_if.slave  bus
);

    localparam int AW = $clog2(WIN_LEN);
    localparam int HW = $clog2(OUT_W + 1);
    localparam logic [63:0]   SAT  = 64'({CNT_W{1'b1}});
    localparam logic [AW-1:0] LAST = AW'(WIN_LEN - 1);

    state_e           state_q, state_d;
    logic [AW-1:0]    cnt_q, cnt_d;
    logic             rdy, accept, at_last, blocked;

    logic             s1_vld, s1_last, s1_mism;
    logic [HW-1:0]    s1_ham;
    logic [OUT_W-1:0] s1_ae, s1_flip;

    logic [CNT_W-1:0] mism_acc_q, ham_acc_q, sae_acc_q;
    logic [CNT_W-1:0] mism_acc_d, ham_acc_d, sae_acc_d;
    logic [OUT_W-1:0] maxe_acc_q, maxe_acc_d;
    logic [CNT_W-1:0] mism_sum, ham_sum, sae_sum;
    logic [OUT_W-1:0] maxe_new;

    logic             res_valid_q, res_valid_d, load;
    logic [CNT_W-1:0] res_mism_q, res_ham_q, res_sae_q;
    logic [CNT_W-1:0] res_mism_d, res_ham_d, res_sae_d;
    logic [OUT_W-1:0] res_maxe_q, res_maxe_d;

    // Last sample waits unless the result slot is free or freeing now.
    assign at_last = (cnt_q == LAST);
    assign blocked = at_last && res_valid_q && !bus.res_ready;

    always_comb begin
        state_d = state_q;
        rdy     = 1'b0;
        unique case (state_q)
            RUN: begin
                rdy = !blocked;
                if (blocked) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (bus.res_ready) begin
                    state_d = RUN;
                end
            end
        endcase
    end

    assign accept = bus.in_valid && rdy;

    always_comb begin
        cnt_d = cnt_q;
        if (accept) begin
            cnt_d = at_last ? '0 : cnt_q + 1'b1;
        end
    end

    max_part_err_diff #(
        .OUT_W (OUT_W),
        .HW    (HW)
    ) u_diff (
        .clk    (clk),
        .rst_n  (rst_n),
        .vld_i  (accept),
        .last_i (accept && at_last),
        .a_i    (bus.approx_w),
        .e_i    (bus.exact_w),
        .vld_o  (s1_vld),
        .last_o (s1_last),
        .mism_o (s1_mism),
        .ham_o  (s1_ham),
        .ae_o   (s1_ae),
        .flip_o (s1_flip)
    );

    assign load = s1_vld && s1_last;

    always_comb begin
        mism_sum = CNT_W'(sat_add(64'(mism_acc_q), 64'(s1_mism), SAT));
        ham_sum  = CNT_W'(sat_add(64'(ham_acc_q), 64'(s1_ham), SAT));
        sae_sum  = CNT_W'(sat_add(64'(sae_acc_q), 64'(s1_ae), SAT));
        maxe_new = (s1_ae > maxe_acc_q) ? s1_ae : maxe_acc_q;

        mism_acc_d = mism_acc_q;
        ham_acc_d  = ham_acc_q;
        sae_acc_d  = sae_acc_q;
        maxe_acc_d = maxe_acc_q;
        if (s1_vld) begin
            mism_acc_d = s1_last ? '0 : mism_sum;
            ham_acc_d  = s1_last ? '0 : ham_sum;
            sae_acc_d  = s1_last ? '0 : sae_sum;
            maxe_acc_d = s1_last ? '0 : maxe_new;
        end

        res_mism_d  = load ? mism_sum : res_mism_q;
        res_ham_d   = load ? ham_sum : res_ham_q;
        res_sae_d   = load ? sae_sum : res_sae_q;
        res_maxe_d  = load ? maxe_new : res_maxe_q;
        res_valid_d = load || (res_valid_q && !bus.res_ready);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RUN;
            cnt_q       <= '0;
            mism_acc_q  <= '0;
            ham_acc_q   <= '0;
            sae_acc_q   <= '0;
            maxe_acc_q  <= '0;
            res_valid_q <= 1'b0;
            res_mism_q  <= '0;
            res_ham_q   <= '0;
            res_sae_q   <= '0;
            res_maxe_q  <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mism_acc_q  <= mism_acc_d;
            ham_acc_q   <= ham_acc_d;
            sae_acc_q   <= sae_acc_d;
            maxe_acc_q  <= maxe_acc_d;
            res_valid_q <= res_valid_d;
            res_mism_q  <= res_mism_d;
            res_ham_q   <= res_ham_d;
            res_sae_q   <= res_sae_d;
            res_maxe_q  <= res_maxe_d;
        end
    end

`ifdef ERR_BITCNT_EN
    logic [OUT_W-1:0][CNT_W-1:0] bc_acc_q, bc_acc_d;
    logic [OUT_W-1:0][CNT_W-1:0] bc_res_q, bc_res_d;
    logic [OUT_W-1:0][CNT_W-1:0] bc_sum;

    always_comb begin
        for (int i = 0; i < OUT_W; i++) begin
            bc_sum[i] = CNT_W'(sat_add(64'(bc_acc_q[i]),
                                       64'(s1_flip[i]), SAT));
        end
        bc_acc_d = bc_acc_q;
        if (s1_vld) begin
            bc_acc_d = s1_last ? '0 : bc_sum;
        end
        bc_res_d = load ? bc_sum : bc_res_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bc_acc_q <= '0;
            bc_res_q <= '0;
        end else begin
            bc_acc_q <= bc_acc_d;
            bc_res_q <= bc_res_d;
        end
    end

    assign bus.res_bitcnt = bc_res_q;
`else
    logic unused_flip;
    assign unused_flip    = ^s1_flip;
    assign bus.res_bitcnt = '0;
`endif

    assign bus.in_ready  = rdy;
    assign bus.res_valid = res_valid_q;
    assign bus.res_mism  = res_mism_q;
    assign bus.res_ham   = res_ham_q;
    assign bus.res_sae   = res_sae_q;
    assign bus.res_maxe  = res_maxe_q;

endmodule

// File: tb/tb_max_part_err_monitor.sv
// Directed bench for max_part_err_monitor, OUT_W=5, WIN_LEN=4.
// Expected res_bitcnt follows ERR_BITCNT_EN.
module tb_max_part_err_monitor;

    localparam int OW = 5;
    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_acc   = 0;
    int   n_res   = 0;
    int   acc0, res0;
    logic [OW*CW-1:0] exp_bc;

    max_part_err_if #(.OUT_W(OW), .CNT_W(CW)) bus ();

    max_part_err_monitor #(
        .OUT_W   (OW),
        .CNT_W   (CW),
        .WIN_LEN (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.in_valid && bus.in_ready) n_acc <= n_acc + 1;
        if (bus.res_valid && bus.res_ready) n_res <= n_res + 1;
    end

    task automatic chk(input string tag,
                       input logic [OW*CW-1:0] obs,
                       input logic [OW*CW-1:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag,
                           input logic [CW-1:0] m,
                           input logic [CW-1:0] h,
                           input logic [CW-1:0] s,
                           input logic [OW-1:0] x);
        chk({tag, "_valid"}, bus.res_valid, 1);
        chk({tag, "_mism"}, bus.res_mism, m);
        chk({tag, "_ham"}, bus.res_ham, h);
        chk({tag, "_sae"}, bus.res_sae, s);
        chk({tag, "_maxe"}, bus.res_maxe, x);
    endtask

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic push(input logic [OW-1:0] a, input logic [OW-1:0] e);
        int g;
        g = 0;
        bus.in_valid = 1'b1;
        bus.approx_w = a;
        bus.exact_w  = e;
        #1;
        while (bus.in_ready !== 1'b1 && g < 20) begin
            @(negedge clk);
            #1;
            g++;
        end
        chk("push_ready", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    initial begin
        exp_bc = '0;
`ifdef ERR_BITCNT_EN
        exp_bc[0*CW +: CW] = 32'd4;
        exp_bc[4*CW +: CW] = 32'd4;
`endif
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.approx_w  = '0;
        bus.exact_w   = '0;
        bus.res_ready = 1'b1;
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_valid", bus.res_valid, 0);
        chk("rst_ready", bus.in_ready, 1);
        chk("rst_mism", bus.res_mism, 0);
        chk("rst_ham", bus.res_ham, 0);
        chk("rst_sae", bus.res_sae, 0);
        chk("rst_maxe", bus.res_maxe, 0);
        chk("rst_bitcnt", bus.res_bitcnt, 0);

        repeat (4) push(5'h13, 5'h13);
        @(negedge clk);
        chk_res("eq", 0, 0, 0, 0);

        push(5'b01010, 5'b01001);
        repeat (3) push(5'h07, 5'h07);
        @(negedge clk);
        chk_res("one", 1, 2, 1, 1);

        push(5'b11111, 5'b00000);
        push(5'b00000, 5'b00011);
        repeat (2) push(5'h0c, 5'h0c);
        @(negedge clk);
        chk_res("two", 2, 7, 34, 31);

        repeat (4) push(5'b10001, 5'b00000);
        @(negedge clk);
        chk_res("bc", 4, 8, 68, 17);
        chk("bc_vec", bus.res_bitcnt, exp_bc);

        @(negedge clk);
        bus.res_ready = 1'b0;
        acc0 = n_acc;
        res0 = n_res;
        repeat (4) push(5'h05, 5'h05);
        push(5'b00001, 5'b00000);
        repeat (2) push(5'h09, 5'h09);
        bus.in_valid = 1'b1;
        bus.approx_w = 5'h09;
        bus.exact_w  = 5'h09;
        #1;
        chk("hold_rdy0", bus.in_ready, 0);
        repeat (3) @(negedge clk);
        #1;
        chk("hold_rdy1", bus.in_ready, 0);
        chk_res("hold_a", 0, 0, 0, 0);
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        #1;
        chk("hold_rdy2", bus.in_ready, 1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk_res("hold_b", 1, 1, 1, 1);
        bus.res_ready = 1'b1;
        @(negedge clk);
        chk("hold_nacc", n_acc - acc0, 8);
        chk("hold_nres", n_res - res0, 2);
        chk("hold_clr", bus.res_valid, 0);

        push(5'b11111, 5'b00000);
        push(5'b11111, 5'b00000);
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", bus.res_valid, 0);
        chk("mrst_ready", bus.in_ready, 1);
        chk("mrst_mism", bus.res_mism, 0);
        chk("mrst_sae", bus.res_sae, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) push(5'h02, 5'h02);
        @(negedge clk);
        chk_res("post", 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
